// File: rtl/wb_regfile_stage_pkg.sv
// Shared types and constants for the writeback stage: flag bit positions,
// the NZCV group type and default widths.
package wb_regfile_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/wb_regfile_stage_regfile_2w4r.sv
// Register storage with two write ports and four write-through read ports.
// Slot 2 is younger, so it wins both the array update and the bypass.
module regfile_2w4r
  import wb_regfile_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = 8,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] rdat0,
  output logic [DATA_W-1:0] rdat1,
  output logic [DATA_W-1:0] rdat2,
  output logic [DATA_W-1:0] rdat3
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic              we1_eff;
  logic              we2_eff;

  // With R0_ZERO the hard-wired register never accepts a write.
  assign we1_eff = we1 && !(R0_ZERO && (wa1 == '0));
  assign we2_eff = we2 && !(R0_ZERO && (wa2 == '0));

  always_comb begin
    mem_d = mem_q;
    if (we1_eff) mem_d[wa1] = wd1;
    if (we2_eff) mem_d[wa2] = wd2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  function automatic logic [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              e1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1,
    input logic              e2,
    input logic [ADDR_W-1:0] a2,
    input logic [DATA_W-1:0] d2
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (e1 && (a1 == ra)) v = d1;
    if (e2 && (a2 == ra)) v = d2;
    if (R0_ZERO && (ra == '0)) v = '0;
    return v;
  endfunction

  assign rdat0 = bypass(ra0, mem_q[ra0], we1_eff, wa1, wd1, we2_eff, wa2, wd2);
  assign rdat1 = bypass(ra1, mem_q[ra1], we1_eff, wa1, wd1, we2_eff, wa2, wd2);
  assign rdat2 = bypass(ra2, mem_q[ra2], we1_eff, wa1, wd1, we2_eff, wa2, wd2);
  assign rdat3 = bypass(ra3, mem_q[ra3], we1_eff, wa1, wd1, we2_eff, wa2, wd2);

endmodule

// File: rtl/wb_regfile_stage.sv
// Dual-slot writeback stage: register file, NZCV flags and retired counter.
// Everything written this cycle is visible combinationally to decode.
module wb_regfile_stage
  import wb_regfile_stage_pkg::*;
#(
  parameter int              DATA_W       = DATA_W_DEF,
  parameter int              NREG         = 8,
  parameter int              ADDR_W       = ADDR_W_DEF,
  parameter bit              R0_ZERO      = 1'b0,
  parameter int              CNT_W        = 32,
  // Reset value of the retired counter; 0 in normal use.
  parameter logic [CNT_W-1:0] RETIRED_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid1,
  input  logic              wb_regwrite1,
  input  logic [ADDR_W-1:0] wb_rd1,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic              wb_flagwrite1,
  input  logic [3:0]        wb_flags1,
  input  logic              wb_valid2,
  input  logic              wb_regwrite2,
  input  logic [ADDR_W-1:0] wb_rd2,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic              wb_flagwrite2,
  input  logic [3:0]        wb_flags2,
  input  logic [ADDR_W-1:0] rs1a,
  input  logic [ADDR_W-1:0] rs1b,
  input  logic [ADDR_W-1:0] rs2a,
  input  logic [ADDR_W-1:0] rs2b,
  output logic [DATA_W-1:0] rd1a,
  output logic [DATA_W-1:0] rd1b,
  output logic [DATA_W-1:0] rd2a,
  output logic [DATA_W-1:0] rd2b,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_fwd,
  output logic [CNT_W-1:0]  retired
);

  flags_t             flags_d;
  logic [CNT_W-1:0]   retired_q;
  logic [CNT_W-1:0]   retired_d;

  regfile_2w4r #(
    .DATA_W  (DATA_W),
    .NREG    (NREG),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .we1   (wb_valid1 & wb_regwrite1),
    .wa1   (wb_rd1),
    .wd1   (wb_data1),
    .we2   (wb_valid2 & wb_regwrite2),
    .wa2   (wb_rd2),
    .wd2   (wb_data2),
    .ra0   (rs1a),
    .ra1   (rs1b),
    .ra2   (rs2a),
    .ra3   (rs2b),
    .rdat0 (rd1a),
    .rdat1 (rd1b),
    .rdat2 (rd2a),
    .rdat3 (rd2b)
  );

  // Whole-group override: the younger slot replaces all four flags.
  always_comb begin
    flags_fwd = flags_q;
    if (wb_valid1 && wb_flagwrite1) flags_fwd = wb_flags1;
    if (wb_valid2 && wb_flagwrite2) flags_fwd = wb_flags2;
    flags_d = flags_fwd;
  end

  always_comb begin
    retired_d = retired_q + CNT_W'(wb_valid1) + CNT_W'(wb_valid2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      retired_q <= RETIRED_INIT;
    end else begin
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: one R0_ZERO=0 instance and one
// R0_ZERO=1 instance with a near-wrap counter, both driven by the same stimulus.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        v1, we1, fw1, v2, we2, fw2;
  logic [2:0]  a1, a2;
  logic [31:0] d1, d2;
  logic [3:0]  f1, f2;
  logic [2:0]  rs1a, rs1b, rs2a, rs2b;

  logic [31:0] m_rd1a, m_rd1b, m_rd2a, m_rd2b, m_ret;
  logic [3:0]  m_fq, m_fwd;
  logic [31:0] z_rd1a, z_rd1b, z_rd2a, z_rd2b, z_ret;
  logic [3:0]  z_fq, z_fwd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile_stage #(.R0_ZERO(1'b0)) dut_m (
    .clk(clk), .reset(reset),
    .wb_valid1(v1), .wb_regwrite1(we1), .wb_rd1(a1), .wb_data1(d1),
    .wb_flagwrite1(fw1), .wb_flags1(f1),
    .wb_valid2(v2), .wb_regwrite2(we2), .wb_rd2(a2), .wb_data2(d2),
    .wb_flagwrite2(fw2), .wb_flags2(f2),
    .rs1a(rs1a), .rs1b(rs1b), .rs2a(rs2a), .rs2b(rs2b),
    .rd1a(m_rd1a), .rd1b(m_rd1b), .rd2a(m_rd2a), .rd2b(m_rd2b),
    .flags_q(m_fq), .flags_fwd(m_fwd), .retired(m_ret)
  );

  wb_regfile_stage #(.R0_ZERO(1'b1), .RETIRED_INIT(32'hFFFF_FFFE)) dut_z (
    .clk(clk), .reset(reset),
    .wb_valid1(v1), .wb_regwrite1(we1), .wb_rd1(a1), .wb_data1(d1),
    .wb_flagwrite1(fw1), .wb_flags1(f1),
    .wb_valid2(v2), .wb_regwrite2(we2), .wb_rd2(a2), .wb_data2(d2),
    .wb_flagwrite2(fw2), .wb_flags2(f2),
    .rs1a(rs1a), .rs1b(rs1b), .rs2a(rs2a), .rs2b(rs2b),
    .rd1a(z_rd1a), .rd1b(z_rd1b), .rd2a(z_rd2a), .rd2b(z_rd2b),
    .flags_q(z_fq), .flags_fwd(z_fwd), .retired(z_ret)
  );

  typedef struct {
    logic        v, we;
    logic [2:0]  rd;
    logic [31:0] d;
    logic        fw;
    logic [3:0]  f;
  } slot_t;

  typedef struct {
    slot_t             s1, s2;
    logic [0:3][2:0]   rs;
    logic [0:3][31:0]  er;
    logic [3:0]        efwd;
    logic [3:0]        efq;
    logic [31:0]       eret;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0; fw1 = 1'b0; f1 = '0;
    v2 = 1'b0; we2 = 1'b0; a2 = '0; d2 = '0; fw2 = 1'b0; f2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #7;
    reset = 1'b0;
    tick();
  endtask

  task automatic apply(input slot_t s1, input slot_t s2);
    v1 = s1.v; we1 = s1.we; a1 = s1.rd; d1 = s1.d; fw1 = s1.fw; f1 = s1.f;
    v2 = s2.v; we2 = s2.we; a2 = s2.rd; d2 = s2.d; fw2 = s2.fw; f2 = s2.f;
  endtask

  initial begin
    //               slot1                                      slot2                                      rs1a..rs2b                     expected rd1a..rd2b                                           fwd    fq     retired
    vecs[0] = '{'{1'b1,1'b1,3'd2,32'h11111111,1'b0,4'h0}, '{1'b1,1'b1,3'd5,32'h0000FFFF,1'b0,4'h0}, {3'd2,3'd5,3'd0,3'd1}, {32'h11111111,32'h0000FFFF,32'h0,32'h0},               4'h0, 4'h0, 32'd2};
    vecs[1] = '{'{1'b1,1'b1,3'd4,32'hAAAA0000,1'b0,4'h0}, '{1'b1,1'b1,3'd4,32'h000000BB,1'b0,4'h0}, {3'd4,3'd2,3'd5,3'd4}, {32'h000000BB,32'h11111111,32'h0000FFFF,32'h000000BB}, 4'h0, 4'h0, 32'd4};
    vecs[2] = '{'{1'b1,1'b0,3'd0,32'h0,1'b1,4'b1000},     '{1'b1,1'b0,3'd0,32'h0,1'b1,4'b0100},     {3'd4,3'd2,3'd5,3'd6}, {32'h000000BB,32'h11111111,32'h0000FFFF,32'h0},        4'b0100, 4'b0100, 32'd6};
    vecs[3] = '{'{1'b1,1'b0,3'd0,32'h0,1'b1,4'b1000},     '{1'b1,1'b1,3'd6,32'h0000600D,1'b0,4'b0001}, {3'd6,3'd4,3'd2,3'd0}, {32'h0000600D,32'h000000BB,32'h11111111,32'h0},     4'b1000, 4'b1000, 32'd8};
    vecs[4] = '{'{1'b0,1'b1,3'd1,32'hDEAD0001,1'b1,4'hF}, '{1'b0,1'b1,3'd3,32'hDEAD0003,1'b1,4'b0011}, {3'd1,3'd3,3'd6,3'd2}, {32'h0,32'h0,32'h0000600D,32'h11111111},             4'b1000, 4'b1000, 32'd8};
    vecs[5] = '{'{1'b0,1'b0,3'd0,32'h0,1'b0,4'h0},        '{1'b1,1'b1,3'd0,32'h12345678,1'b1,4'b0010}, {3'd0,3'd0,3'd4,3'd5}, {32'h12345678,32'h12345678,32'h000000BB,32'h0000FFFF}, 4'b0010, 4'b0010, 32'd9};
    vecs[6] = '{'{1'b1,1'b1,3'd7,32'h77777777,1'b0,4'h0}, '{1'b1,1'b0,3'd7,32'h0,1'b0,4'h0},        {3'd7,3'd0,3'd6,3'd4}, {32'h77777777,32'h12345678,32'h0000600D,32'h000000BB}, 4'b0010, 4'b0010, 32'd11};
    vecs[7] = '{'{1'b1,1'b1,3'd1,32'h1,1'b1,4'b0101},     '{1'b1,1'b1,3'd1,32'h2,1'b0,4'hF},        {3'd1,3'd1,3'd7,3'd5}, {32'h2,32'h2,32'h77777777,32'h0000FFFF},               4'b0101, 4'b0101, 32'd13};
    vecs[8] = '{'{1'b0,1'b0,3'd0,32'h0,1'b0,4'h0},        '{1'b0,1'b0,3'd0,32'h0,1'b0,4'h0},        {3'd1,3'd7,3'd6,3'd4}, {32'h2,32'h77777777,32'h0000600D,32'h000000BB},       4'b0101, 4'b0101, 32'd13};

    idle();
    rs1a = 3'd0; rs1b = 3'd3; rs2a = 3'd5; rs2b = 3'd7;
    reset = 1'b1;
    #12;
    chk("rst_rd1a", m_rd1a, 32'h0);
    chk("rst_rd1b", m_rd1b, 32'h0);
    chk("rst_rd2a", m_rd2a, 32'h0);
    chk("rst_rd2b", m_rd2b, 32'h0);
    chk("rst_flags_q", {28'h0, m_fq}, 32'h0);
    chk("rst_flags_fwd", {28'h0, m_fwd}, 32'h0);
    chk("rst_retired", m_ret, 32'h0);
    chk("rst_retired_init", z_ret, 32'hFFFF_FFFE);
    reset = 1'b0;
    tick();

    // Reset asserted while a write of r3 is pending: the write must be lost.
    v1 = 1'b1; we1 = 1'b1; a1 = 3'd3; d1 = 32'hDEADBEEF;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 idle();
    #2 reset = 1'b0;
    rs1a = 3'd3;
    #1 chk("rst_midwrite_r3", m_rd1a, 32'h0);
    tick();
    chk("rst_midwrite_r3_after", m_rd1a, 32'h0);
    chk("rst_midwrite_retired", m_ret, 32'h0);

    // Counter wrap from the preloaded value.
    do_reset();
    v1 = 1'b1; v2 = 1'b1;
    tick();
    chk("wrap_dual", z_ret, 32'h0000_0000);
    chk("count_dual", m_ret, 32'd2);
    v2 = 1'b0;
    tick();
    chk("wrap_single", z_ret, 32'h0000_0001);
    chk("count_single", m_ret, 32'd3);
    idle();
    tick();
    chk("count_idle", z_ret, 32'h0000_0001);

    // Table of writes, bypass reads and flag updates.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].s1, vecs[i].s2);
      rs1a = vecs[i].rs[0]; rs1b = vecs[i].rs[1];
      rs2a = vecs[i].rs[2]; rs2b = vecs[i].rs[3];
      #3;
      chk($sformatf("v%0d_rd1a", i), m_rd1a, vecs[i].er[0]);
      chk($sformatf("v%0d_rd1b", i), m_rd1b, vecs[i].er[1]);
      chk($sformatf("v%0d_rd2a", i), m_rd2a, vecs[i].er[2]);
      chk($sformatf("v%0d_rd2b", i), m_rd2b, vecs[i].er[3]);
      chk($sformatf("v%0d_flags_fwd", i), {28'h0, m_fwd}, {28'h0, vecs[i].efwd});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flags_q", i), {28'h0, m_fq}, {28'h0, vecs[i].efq});
      chk($sformatf("v%0d_retired", i), m_ret, vecs[i].eret);
    end

    // r0 after the table: plain register vs hard-wired zero, registered path.
    idle();
    rs1a = 3'd0; rs1b = 3'd4; rs2a = 3'd0; rs2b = 3'd0;
    #1;
    chk("r0_reg_plain", m_rd1a, 32'h12345678);
    chk("r0_reg_zero", z_rd1a, 32'h0);
    chk("r4_reg_zero_inst", z_rd1b, 32'h000000BB);

    // r0 on the bypass path, from both slots.
    v1 = 1'b1; we1 = 1'b1; a1 = 3'd0; d1 = 32'hCAFE0000;
    #1;
    chk("r0_byp1_plain", m_rd2a, 32'hCAFE0000);
    chk("r0_byp1_zero", z_rd2a, 32'h0);
    tick();
    v1 = 1'b0; we1 = 1'b0;
    v2 = 1'b1; we2 = 1'b1; a2 = 3'd0; d2 = 32'h0000BEEF;
    #1;
    chk("r0_byp2_plain", m_rd2b, 32'h0000BEEF);
    chk("r0_byp2_zero", z_rd2b, 32'h0);
    chk("r0_reg_after_w1_plain", m_rd1b, 32'h000000BB);
    tick();
    idle();
    #1;
    chk("r0_final_plain", m_rd1a, 32'h0000BEEF);
    chk("r0_final_zero", z_rd1a, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register in the dual-slot pipeline.
- Slot 1 carries the ALU result; slot 2 carries the zero-extended load result. Slot 2 is younger in program order.
- Holds the architectural register file, the NZCV flag register and a retired-instruction counter.
- Serves four write-through-bypassed read ports and one bypassed flag read to the decode stage.

Parameters:
DATA_W, 32, register and write-data width
NREG, 8, number of architectural registers
ADDR_W, 3, register address width (clog2 of NREG)
R0_ZERO, 0, if 1 then register 0 reads as 0 and ignores writes
CNT_W, 32, retired-counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wb_valid1  in  1  slot-1 instruction present
wb_regwrite1  in  1  slot-1 register write enable
wb_rd1  in  ADDR_W  slot-1 destination register
wb_data1  in  DATA_W  slot-1 write data (ALU result)
wb_flagwrite1  in  1  slot-1 flag update enable
wb_flags1  in  4  slot-1 flags {N,Z,C,V}
wb_valid2, wb_regwrite2, wb_rd2, wb_data2, wb_flagwrite2, wb_flags2  in  same widths  slot-2 equivalents (load data)
rs1a, rs1b, rs2a, rs2b  in  ADDR_W  read addresses
rd1a, rd1b, rd2a, rd2b  out  DATA_W  read data, combinational
flags_q  out  4  registered NZCV
flags_fwd  out  4  NZCV including this cycle's update
retired  out  CNT_W  count of retired valid instructions

Behaviour:
- Reset: the only clock and reset are clk and reset. Reset is asynchronous and active-high.
  - While reset is high, all NREG registers, flags_q and retired are 0.
  - Read outputs reflect the cleared file.
- Writes:
  - A slot writes on a rising edge when wb_validN & wb_regwriteN.
  - With no valid write, the slot is ignored; its enable inputs are don't-care.
- Same-rd conflict: if both slots write the same rd in one cycle, slot 2 wins. The final value equals wb_data2.
- R0_ZERO=1: writes to address 0 are dropped, and reads of address 0 return 0, including on the bypass path.
- Read bypass: each read port returns the register contents, overridden by the slot-1 write data if it matches rs, then by the slot-2 write data if it matches rs.
  - Effectively zero-latency write-to-read forwarding.
  - No other latency exists in the block.
- Flags: updated on an edge if either slot has valid & flagwrite.
  - Slot 2 overrides slot 1 as a whole 4-bit group; there is no per-bit merge.
  - flags_fwd applies the same priority combinationally over flags_q.
- Retired counter: on each edge, retired += wb_valid1 + wb_valid2 (0, 1 or 2).
  - Counts regardless of the write enables.
  - Wraps modulo 2^CNT_W with no saturation.
  - Example: 0xFFFFFFFF + 2 → 0x00000001.
- Reset mid-operation: writes pending in the cycle reset asserts are discarded. Reset has priority over every write.
- No stall input: this stage always accepts. Flow control is the responsibility of upstream stages.
- Widths: the retired increment is zero-extended to CNT_W. Addresses at or above NREG cannot occur when NREG = 2^ADDR_W.

Decomposition:
- Shared package:
  - Flag-bit index constants N=3, Z=2, C=1, V=0.
  - The 4-bit flags typedef.
  - ADDR_W/DATA_W defaults.
- One natural sub-module: regfile_2w4r, the storage array with 2 write and 4 read ports plus the bypass mux.
  - Flags and counter logic stay in the top.

Test Plan:
1. Reset then read all ports → all 0, flags_q=0000, retired=0. Assert reset mid-write of r3=0xDEADBEEF → r3 stays 0.
2. Slot1 r2=0x11111111, slot2 r5=0x0000FFFF, same cycle → next cycle r2 and r5 hold those values, retired=2. rs1a=2 in the write cycle already returns 0x11111111 through the bypass.
3. Both slots write r4: slot1 0xAAAA0000, slot2 0x000000BB → r4=0x000000BB. The read bypass in the same cycle shows 0x000000BB.
4. Flags: slot1 flags 1000 with flagwrite, slot2 0100 with flagwrite → flags_fwd=0100 immediately, flags_q=0100 next cycle. Slot2 valid but flagwrite=0 → flags=1000.
5. R0_ZERO=1: write r0=0x12345678 → reads of r0, both bypassed and registered, return 0. With R0_ZERO=0 the read returns 0x12345678.
6. Preload retired to 0xFFFFFFFE via 2147483647 dual-valid cycles, or force via a bench-only reset value. Then one cycle with both slots valid → retired=0x00000000. Next a single slot valid → 0x00000001.
